// File: rtl/cic_interp_duc.sv
// Multichannel CIC interpolator for the DUC transmit path.
// Comb stages at the input rate, zero-stuff by R, integrators at the output rate,
// then arithmetic shift and saturation. Channels are time-multiplexed per frame.
module cic_interp_duc #(
    parameter int INPUT_WIDTH           = 16,
    parameter int MIDDLE_WIDTH          = 40,
    parameter int OUTPUT_WIDTH          = 16,
    parameter int CIC_NUMSECS           = 2,
    parameter int CIC_MAX_RATE          = 16,
    parameter int CIC_MAX_CHANNELS      = 2,
    parameter int CIC_CONFIG_DATA_WIDTH = 16
) (
    input  logic                                CLK,
    input  logic                                nRST,
    input  logic                                isConfig,
    output logic                                isConfigACK,
    output logic                                isConfigDone,
    input  logic [CIC_CONFIG_DATA_WIDTH-1:0]    Data_Config_In,
    input  logic signed [INPUT_WIDTH-1:0]       Data_In,
    input  logic                                Data_In_Valid,
    input  logic [3:0]                          Data_In_ChIdx,
    output logic                                Data_In_Ready,
    output logic signed [OUTPUT_WIDTH-1:0]      Data_Out,
    output logic                                Data_Out_Valid,
    output logic [3:0]                          Data_Out_ChIdx,
    output logic                                Data_In_Err
);

    localparam int RW = $clog2(CIC_MAX_RATE + 1);
    localparam int SW = $clog2(MIDDLE_WIDTH);
    localparam int CW = (CIC_MAX_CHANNELS > 1) ? $clog2(CIC_MAX_CHANNELS) : 1;
    localparam int CD = 1 << CW;

    localparam logic signed [MIDDLE_WIDTH-1:0] SAT_HI =
        {{(MIDDLE_WIDTH-OUTPUT_WIDTH+1){1'b0}}, {(OUTPUT_WIDTH-1){1'b1}}};
    localparam logic signed [MIDDLE_WIDTH-1:0] SAT_LO = ~SAT_HI;
    localparam logic [OUTPUT_WIDTH-1:0] OUT_MAX = {1'b0, {(OUTPUT_WIDTH-1){1'b1}}};
    localparam logic [OUTPUT_WIDTH-1:0] OUT_MIN = {1'b1, {(OUTPUT_WIDTH-1){1'b0}}};

    typedef enum logic {ST_IN, ST_OUT} stateT;

    stateT state, stateNext;

    logic [1:0]        cfgCnt;
    logic [4:0]        numCh;
    logic [RW-1:0]     rate;
    logic [SW-1:0]     scale;
    logic [3:0]        kCnt;
    logic [RW-1:0]     phase;
    logic [CW-1:0]     kIdx;
    logic              readyReg;

    logic signed [MIDDLE_WIDTH-1:0] combDly [CIC_NUMSECS][CD];
    logic signed [MIDDLE_WIDTH-1:0] integ   [CIC_NUMSECS][CD];
    logic signed [MIDDLE_WIDTH-1:0] combOut [CD];

    logic signed [MIDDLE_WIDTH-1:0] combIn  [CIC_NUMSECS+1];
    logic signed [MIDDLE_WIDTH-1:0] integIn [CIC_NUMSECS+1];
    logic signed [MIDDLE_WIDTH-1:0] shifted;
    logic [OUTPUT_WIDTH-1:0]        dataOutNext;

    logic [4:0]    numChCfg;
    logic [RW-1:0] rateCfg;
    logic [SW-1:0] scaleCfg;

    logic cfgTake, cfgLast, dataTake, accept, dropped;
    logic chLast, phLast, outStep, readyNext;

    assign kIdx          = kCnt[CW-1:0];
    assign Data_In_Ready = readyReg;

    // State register
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state <= ST_IN;
        else       state <= stateNext;
    end

    // Next-state: leave ST_IN on the last channel accept, leave ST_OUT after R*NUMCH outputs
    always_comb begin
        stateNext = state;
        unique case (state)
            ST_IN:  if (accept && chLast) stateNext = ST_OUT;
            ST_OUT: if (chLast && phLast) stateNext = ST_IN;
            default: stateNext = ST_IN;
        endcase
    end

    // Output decode: strobes for config capture, sample accept/drop and output compute
    always_comb begin
        cfgTake   = (state == ST_IN) && isConfig;
        cfgLast   = cfgTake && (cfgCnt == 2'd2);
        dataTake  = (state == ST_IN) && readyReg && !isConfig && Data_In_Valid;
        accept    = dataTake && (Data_In_ChIdx == kCnt);
        dropped   = dataTake && (Data_In_ChIdx != kCnt);
        chLast    = ({1'b0, kCnt} == (numCh - 5'd1));
        phLast    = (phase == (rate - RW'(1)));
        outStep   = (state == ST_OUT);
        // Ready is registered so it reflects the state after this edge, staying low
        // while a config sequence is partially collected.
        readyNext = (stateNext == ST_IN) && (cfgTake ? cfgLast : (cfgCnt == 2'd0));
    end

    // Config word clamping
    always_comb begin
        if (Data_Config_In == '0)
            numChCfg = 5'd1;
        else if (Data_Config_In > CIC_CONFIG_DATA_WIDTH'(CIC_MAX_CHANNELS))
            numChCfg = 5'(CIC_MAX_CHANNELS);
        else
            numChCfg = 5'(Data_Config_In);

        if (Data_Config_In == '0)
            rateCfg = RW'(1);
        else if (Data_Config_In > CIC_CONFIG_DATA_WIDTH'(CIC_MAX_RATE))
            rateCfg = RW'(CIC_MAX_RATE);
        else
            rateCfg = RW'(Data_Config_In);

        if (Data_Config_In > CIC_CONFIG_DATA_WIDTH'(MIDDLE_WIDTH - 1))
            scaleCfg = SW'(MIDDLE_WIDTH - 1);
        else
            scaleCfg = SW'(Data_Config_In);
    end

    // Comb and integrator chains for the current channel, combinational within the cycle
    always_comb begin
        combIn[0] = {{(MIDDLE_WIDTH-INPUT_WIDTH){Data_In[INPUT_WIDTH-1]}}, Data_In};
        for (int unsigned j = 0; j < CIC_NUMSECS; j++)
            combIn[j+1] = combIn[j] - combDly[j][kIdx];

        integIn[0] = (phase == '0) ? combOut[kIdx] : '0;
        for (int unsigned j = 0; j < CIC_NUMSECS; j++)
            integIn[j+1] = integ[j][kIdx] + integIn[j];
    end

    // Output scaling: arithmetic shift then saturate to the output range
    always_comb begin
        shifted = integIn[CIC_NUMSECS] >>> scale;
        if (shifted > SAT_HI)
            dataOutNext = OUT_MAX;
        else if (shifted < SAT_LO)
            dataOutNext = OUT_MIN;
        else
            dataOutNext = shifted[OUTPUT_WIDTH-1:0];
    end

    // Datapath, config registers, counters and registered outputs
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cfgCnt         <= '0;
            numCh          <= 5'd1;
            rate           <= RW'(1);
            scale          <= '0;
            kCnt           <= '0;
            phase          <= '0;
            readyReg       <= 1'b0;
            isConfigACK    <= 1'b0;
            isConfigDone   <= 1'b0;
            Data_In_Err    <= 1'b0;
            Data_Out       <= '0;
            Data_Out_Valid <= 1'b0;
            Data_Out_ChIdx <= '0;
            for (int unsigned c = 0; c < CD; c++) begin
                combOut[c] <= '0;
                for (int unsigned j = 0; j < CIC_NUMSECS; j++) begin
                    combDly[j][c] <= '0;
                    integ[j][c]   <= '0;
                end
            end
        end else begin
            readyReg       <= readyNext;
            isConfigACK    <= cfgTake;
            isConfigDone   <= cfgLast;
            Data_In_Err    <= dropped;
            Data_Out_Valid <= outStep;

            if (cfgTake) begin
                unique case (cfgCnt)
                    2'd0:    numCh <= numChCfg;
                    2'd1:    rate  <= rateCfg;
                    default: scale <= scaleCfg;
                endcase
                cfgCnt <= cfgLast ? 2'd0 : cfgCnt + 2'd1;
                // Any partially collected frame is abandoned at the first config word.
                kCnt   <= '0;
                phase  <= '0;
                if (cfgLast) begin
                    for (int unsigned c = 0; c < CD; c++) begin
                        combOut[c] <= '0;
                        for (int unsigned j = 0; j < CIC_NUMSECS; j++) begin
                            combDly[j][c] <= '0;
                            integ[j][c]   <= '0;
                        end
                    end
                end
            end else if (accept) begin
                for (int unsigned j = 0; j < CIC_NUMSECS; j++)
                    combDly[j][kIdx] <= combIn[j];
                combOut[kIdx] <= combIn[CIC_NUMSECS];
                kCnt          <= chLast ? 4'd0 : kCnt + 4'd1;
                phase         <= '0;
            end else if (outStep) begin
                for (int unsigned j = 0; j < CIC_NUMSECS; j++)
                    integ[j][kIdx] <= integIn[j+1];
                Data_Out       <= dataOutNext;
                Data_Out_ChIdx <= kCnt;
                kCnt           <= chLast ? 4'd0 : kCnt + 4'd1;
                if (chLast)
                    phase <= phLast ? '0 : phase + RW'(1);
            end
        end
    end

endmodule

// File: tb/tb_cic_interp_duc.sv
// Directed bench for cic_interp_duc with hand-computed expected sequences.
module tb_cic_interp_duc;

    logic               CLK;
    logic               nRST;
    logic               isConfig;
    logic               isConfigACK;
    logic               isConfigDone;
    logic [15:0]        Data_Config_In;
    logic signed [15:0] Data_In;
    logic               Data_In_Valid;
    logic [3:0]         Data_In_ChIdx;
    logic               Data_In_Ready;
    logic signed [15:0] Data_Out;
    logic               Data_Out_Valid;
    logic [3:0]         Data_Out_ChIdx;
    logic               Data_In_Err;

    int total = 0;
    int bad   = 0;
    int outVal[$];
    int outCh[$];

    cic_interp_duc #(
        .INPUT_WIDTH(16), .MIDDLE_WIDTH(40), .OUTPUT_WIDTH(16), .CIC_NUMSECS(2),
        .CIC_MAX_RATE(16), .CIC_MAX_CHANNELS(2), .CIC_CONFIG_DATA_WIDTH(16)
    ) dut (
        .CLK(CLK), .nRST(nRST),
        .isConfig(isConfig), .isConfigACK(isConfigACK), .isConfigDone(isConfigDone),
        .Data_Config_In(Data_Config_In),
        .Data_In(Data_In), .Data_In_Valid(Data_In_Valid), .Data_In_ChIdx(Data_In_ChIdx),
        .Data_In_Ready(Data_In_Ready),
        .Data_Out(Data_Out), .Data_Out_Valid(Data_Out_Valid), .Data_Out_ChIdx(Data_Out_ChIdx),
        .Data_In_Err(Data_In_Err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic cfgWord(input int w, input string tag, input int expDone);
        isConfig = 1'b1;
        Data_Config_In = 16'(w);
        tick();
        isConfig = 1'b0;
        chk({tag, "_ack"}, int'(isConfigACK), 1);
        chk({tag, "_done"}, int'(isConfigDone), expDone);
    endtask

    task automatic sendCfg(input int a, input int b, input int c);
        cfgWord(a, "cfg0", 0);
        cfgWord(b, "cfg1", 0);
        cfgWord(c, "cfg2", 1);
    endtask

    task automatic waitReady();
        int guard = 0;
        while (!Data_In_Ready && guard < 50) begin
            tick();
            guard++;
        end
        if (!Data_In_Ready) chk("ready_wait", int'(Data_In_Ready), 1);
    endtask

    // Feed one frame (ch0 = x0, ch1 = x1) and collect nOut outputs into the queues
    task automatic runFrame(input int nch, input int x0, input int x1, input int nOut);
        int n = 0;
        int guard = 0;
        waitReady();
        for (int c = 0; c < nch; c++) begin
            Data_In_Valid = 1'b1;
            Data_In_ChIdx = 4'(c);
            Data_In = 16'((c == 0) ? x0 : x1);
            tick();
        end
        Data_In_Valid = 1'b0;
        while (n < nOut && guard < nOut + 10) begin
            tick();
            guard++;
            if (Data_Out_Valid) begin
                outVal.push_back(int'(Data_Out));
                outCh.push_back(int'(Data_Out_ChIdx));
                n++;
            end
        end
        if (n < nOut) chk("out_count", n, nOut);
    endtask

    task automatic checkSeq(input string tag, input int exp[$]);
        chk({tag, "_len"}, outVal.size(), exp.size());
        for (int i = 0; i < exp.size(); i++)
            chk($sformatf("%s_%0d", tag, i), (i < outVal.size()) ? outVal[i] : -99999, exp[i]);
    endtask

    initial begin
        int e[$];
        int nv;
        nRST = 1'b0;
        isConfig = 1'b0;
        Data_Config_In = '0;
        Data_In = '0;
        Data_In_Valid = 1'b0;
        Data_In_ChIdx = '0;

        // Reset state
        #3;
        chk("rst_out",   int'(Data_Out), 0);
        chk("rst_valid", int'(Data_Out_Valid), 0);
        chk("rst_ready", int'(Data_In_Ready), 0);
        chk("rst_ack",   int'(isConfigACK), 0);
        tick();
        tick();
        nRST = 1'b1;
        #1;
        chk("rel_ready0", int'(Data_In_Ready), 0);
        tick();
        chk("rel_ready1", int'(Data_In_Ready), 1);

        // Defaults NUMCH=1, R=1: impulse passes with unity gain
        outVal.delete(); outCh.delete();
        runFrame(1, 1, 0, 1);
        runFrame(1, 0, 0, 1);
        e = '{1, 0};
        checkSeq("dflt", e);

        // 1. Config handshake with a gap between words
        cfgWord(1, "t1w0", 0);
        chk("t1_ready_w0", int'(Data_In_Ready), 0);
        tick();
        chk("t1_gap_ack", int'(isConfigACK), 0);
        chk("t1_gap_ready", int'(Data_In_Ready), 0);
        cfgWord(4, "t1w1", 0);
        chk("t1_ready_w1", int'(Data_In_Ready), 0);
        cfgWord(0, "t1w2", 1);
        tick();
        chk("t1_done_once", int'(isConfigDone), 0);
        chk("t1_ready_after", int'(Data_In_Ready), 1);

        // Clamp readback: NUMCH=0 -> 1, R=99 -> 16
        sendCfg(0, 99, 0);
        outVal.delete(); outCh.delete();
        runFrame(1, 1, 0, 16);
        chk("rb_count", outVal.size(), 16);
        chk("rb_first", (outVal.size() > 0) ? outVal[0] : -1, 1);
        chk("rb_last", (outVal.size() > 15) ? outVal[15] : -1, 16);
        chk("rb_ready", int'(Data_In_Ready), 1);
        tick();
        chk("rb_no_extra", int'(Data_Out_Valid), 0);

        // 2. Impulse, R=4
        sendCfg(1, 4, 0);
        outVal.delete(); outCh.delete();
        runFrame(1, 1, 0, 4); runFrame(1, 0, 0, 4); runFrame(1, 0, 0, 4);
        e = '{1, 2, 3, 4, 3, 2, 1, 0, 0, 0, 0, 0};
        checkSeq("imp", e);

        // 3. Step, R=4
        sendCfg(1, 4, 0);
        outVal.delete(); outCh.delete();
        runFrame(1, 1, 0, 4); runFrame(1, 1, 0, 4); runFrame(1, 1, 0, 4);
        e = '{1, 2, 3, 4, 4, 4, 4, 4, 4, 4, 4, 4};
        checkSeq("step", e);

        // 4. Saturation
        sendCfg(1, 4, 0);
        outVal.delete(); outCh.delete();
        runFrame(1, 32767, 0, 4); runFrame(1, 32767, 0, 4); runFrame(1, 32767, 0, 4);
        e = '{32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767};
        checkSeq("satp", e);
        sendCfg(1, 4, 2);
        outVal.delete(); outCh.delete();
        runFrame(1, 32767, 0, 4); runFrame(1, 32767, 0, 4);
        e = '{8191, 16383, 24575, 32767, 32767, 32767, 32767, 32767};
        checkSeq("sats2", e);
        sendCfg(1, 4, 0);
        outVal.delete(); outCh.delete();
        runFrame(1, -32768, 0, 4); runFrame(1, -32768, 0, 4);
        e = '{-32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768};
        checkSeq("satn", e);

        // 5. Two channels, R=2
        sendCfg(2, 2, 0);
        outVal.delete(); outCh.delete();
        runFrame(2, 1, -1, 4); runFrame(2, 0, 0, 4);
        e = '{1, -1, 2, -2, 1, -1, 0, 0};
        checkSeq("two", e);
        for (int i = 0; i < 8; i++)
            chk($sformatf("two_ch_%0d", i), (i < outCh.size()) ? outCh[i] : -1, i % 2);
        // Wrong channel: dropped, error pulse, k unchanged
        waitReady();
        Data_In_Valid = 1'b1; Data_In_ChIdx = 4'd1; Data_In = 16'sd5;
        tick();
        Data_In_Valid = 1'b0;
        chk("err_pulse", int'(Data_In_Err), 1);
        chk("err_ready", int'(Data_In_Ready), 1);
        tick();
        chk("err_clear", int'(Data_In_Err), 0);
        outVal.delete(); outCh.delete();
        runFrame(2, 0, 0, 4);
        e = '{0, 0, 0, 0};
        checkSeq("err_ign", e);

        // 6a. Config mid-frame discards ch0 already accepted
        sendCfg(2, 2, 0);
        waitReady();
        Data_In_Valid = 1'b1; Data_In_ChIdx = 4'd0; Data_In = 16'sd7;
        tick();
        Data_In_Valid = 1'b0;
        sendCfg(2, 2, 0);
        outVal.delete(); outCh.delete();
        runFrame(2, 1, 0, 4);
        e = '{1, 0, 2, 0};
        checkSeq("midcfg", e);

        // 6b. Config ignored in ST_OUT, then reset during ST_OUT
        sendCfg(1, 16, 0);
        waitReady();
        Data_In_Valid = 1'b1; Data_In_ChIdx = 4'd0; Data_In = 16'sd1;
        tick();
        Data_In_Valid = 1'b0;
        isConfig = 1'b1; Data_Config_In = 16'd2;
        tick();
        isConfig = 1'b0;
        chk("out_cfg_noack", int'(isConfigACK), 0);
        chk("out_valid", int'(Data_Out_Valid), 1);
        tick();
        #2;
        nRST = 1'b0;
        #1;
        chk("mrst_out", int'(Data_Out), 0);
        chk("mrst_valid", int'(Data_Out_Valid), 0);
        chk("mrst_ready", int'(Data_In_Ready), 0);
        chk("mrst_ch", int'(Data_Out_ChIdx), 0);
        tick();
        nRST = 1'b1;
        #1;
        chk("mrel_ready0", int'(Data_In_Ready), 0);
        tick();
        chk("mrel_ready1", int'(Data_In_Ready), 1);
        nv = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (Data_Out_Valid) nv++;
        end
        chk("mrst_no_partial", nv, 0);
        outVal.delete(); outCh.delete();
        runFrame(1, 1, 0, 1);
        runFrame(1, 0, 0, 1);
        e = '{1, 0};
        checkSeq("post_rst", e);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cic_interp_duc.md
Name: cic_interp_duc

Overview:
- Multichannel CIC interpolation filter for the DUC transmit path, mirroring the DDC decimating CIC.
- Data path: comb stages at the input rate, then zero-stuff upsample by R, then integrator stages at the output rate, then shift/saturate scaling.
- Channels are time-multiplexed, frame-based, with up to 16 channels.
- Interpolation rate, active channel count and output scale are loaded at run time through the same three-word config handshake used by the CIC blocks.

Parameters:
- INPUT_WIDTH, 16, signed input sample width.
- MIDDLE_WIDTH, 40, internal comb/integrator width. Must satisfy MIDDLE_WIDTH >= INPUT_WIDTH + CIC_NUMSECS*log2(CIC_MAX_RATE).
- OUTPUT_WIDTH, 16, signed output width.
- CIC_NUMSECS, 2, number of comb stages and number of integrator stages (1..6, compile-time). Differential delay is fixed at 1.
- CIC_MAX_RATE, 16, maximum interpolation rate R.
- CIC_MAX_CHANNELS, 2, channel state depth (1..16).
- CIC_CONFIG_DATA_WIDTH, 16, config word width.

Ports:
- CLK  in  1  clock.
- nRST  in  1  asynchronous active-low reset.
- isConfig  in  1  config word strobe.
- isConfigACK  out  1  one-cycle pulse per config word captured.
- isConfigDone  out  1  one-cycle pulse after the third word.
- Data_Config_In  in  CIC_CONFIG_DATA_WIDTH  config word.
- Data_In  in  INPUT_WIDTH  signed sample.
- Data_In_Valid  in  1  sample valid.
- Data_In_ChIdx  in  4  sample channel index.
- Data_In_Ready  out  1  block accepts a sample this cycle.
- Data_Out  out  OUTPUT_WIDTH  signed scaled sample.
- Data_Out_Valid  out  1  output valid. There is no backpressure on the output.
- Data_Out_ChIdx  out  4  output channel index.
- Data_In_Err  out  1  one-cycle pulse when an input sample is dropped.

Behaviour:
- Reset (nRST low, asynchronous):
  - Outputs: Data_Out=0, Data_Out_Valid=0, Data_Out_ChIdx=0, isConfigACK=0, isConfigDone=0, Data_In_Err=0, Data_In_Ready=0.
  - Registers: NUMCH=1, R=1, SCALE=0, all comb delay and integrator registers 0, state ST_IN, counters 0.
  - Data_In_Ready goes to 1 on the first clock after release.
- Config:
  - Accepted only in ST_IN. isConfig has priority over Data_In_Valid and discards any partially collected frame.
  - Words arrive on consecutive isConfig-high cycles (gaps allowed), in order: word0 NUMCH, word1 R, word2 SCALE.
  - isConfigACK pulses the cycle after each capture.
  - After word2: isConfigDone pulses with the last ACK, and all comb/integrator state and counters clear to 0.
  - Data_In_Ready=0 from the first word until Done.
  - Clamping: NUMCH 0->1, NUMCH >CIC_MAX_CHANNELS -> CIC_MAX_CHANNELS; R 0->1, R >CIC_MAX_RATE -> CIC_MAX_RATE; SCALE >MIDDLE_WIDTH-1 -> MIDDLE_WIDTH-1.
  - isConfig in ST_OUT is ignored: no ACK.
- ST_IN (Data_In_Ready=1):
  - A sample is accepted when Data_In_Valid=1 and Data_In_ChIdx equals the expected channel counter k.
  - On a mismatch the sample is dropped, Data_In_Err pulses next cycle, and k is unchanged.
  - On accept, the sign-extended sample x passes through CIC_NUMSECS combs: c_j = c_{j-1} - d_j[k], then d_j[k] <= c_{j-1}. The final c is stored as comb_out[k] and k increments.
  - When k reaches NUMCH, go to ST_OUT. Ready drops in the same cycle as the last accept's registered update.
- ST_OUT (Data_In_Ready=0):
  - Emits R*NUMCH samples, one per clock, in order phase p=0..R-1, channel k=0..NUMCH-1 within each phase.
  - Integrator input is comb_out[k] when p=0, else 0.
  - Chain: i_1 <= i_1[k] + in, then i_j <= i_j[k] + new i_{j-1}. The chain is combinational within the cycle.
  - After the last sample return to ST_IN with k=0. There are no idle cycles between output samples.
- Arithmetic:
  - All adders are two's-complement modulo 2^MIDDLE_WIDTH; wrap is intentional.
  - Scaling: arithmetic right shift of i_N by SCALE, then saturate to [-2^(OUTPUT_WIDTH-1), 2^(OUTPUT_WIDTH-1)-1].
  - DC gain is R^(CIC_NUMSECS-1).
- Latency: Data_Out, Data_Out_Valid and Data_Out_ChIdx are registered, valid 1 cycle after the ST_OUT compute cycle. Data_Out holds its last value when Valid=0.
- Reset mid-frame: all state clears; no partial output is produced after reset.

Test Plan:
1. Config handshake: send words 1, 4, 0. Required: 3 ACK pulses, 1 Done coincident with the third ACK, Data_In_Ready low from the first word until Done. Then send NUMCH=0, R=99. Required: readback behaviour matches NUMCH=1, R=16.
2. Impulse, NUMSECS=2, R=4, NUMCH=1, SCALE=0: input 1 followed by zeros. Required output: 1,2,3,4,3,2,1,0,0,...
3. Step response, same config, constant input 1. Required output: 1,2,3,4,4,4,...
4. Saturation: constant input 0x7FFF with SCALE=0. Required: steady output 0x7FFF (32767*4 saturated). Reconfigure SCALE=2. Required: steady output 32767. Repeat with -32768 and SCALE=0. Required: 0x8000.
5. Two channels, NUMCH=2, R=2: ch0 impulse 1, ch1 impulse -1. Required output (value/ChIdx): 1/0, -1/1, 2/0, -2/1, 1/0, -1/1, 0/0, 0/1. Sending ch1 when ch0 is expected: Data_In_Err pulses and the sample is ignored.
6. Mid-frame events: assert isConfig after ch0 is accepted. Required: partial frame discarded, state cleared. Assert nRST during ST_OUT. Required: immediate zero outputs, Valid=0, and Ready=1 one cycle after release.
